mac_accum_ctrl: RTL and testbench
=================================

MAC_ACCUM_CTRL -- requirements
Module: mac_accum_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width, signed two's complement.
REQ-002 Parameter ACC_WIDTH, default 20: accumulator and result width; must be >= 2*WIDTH.
REQ-003 Parameter LEN, default 4: operand pairs per dot product; must be >= 1.
REQ-004 Port clk_n, input, 1: the one clock; all state updates on its falling edge.
REQ-005 Port rst_n, input, 1: asynchronous active-high reset.
REQ-006 Port start, input, 1: begin a new dot product; sampled only in IDLE.
REQ-007 Port a_in, input, WIDTH: signed operand A.
REQ-008 Port b_in, input, WIDTH: signed operand B.
REQ-009 Port in_valid, input, 1: a_in/b_in hold a valid pair.
REQ-010 Port in_ready, output, 1: block accepts a pair this cycle.
REQ-011 Port result, output, ACC_WIDTH: final accumulated sum, held stable between ld pulses.
REQ-012 Port ld, output, 1: one-cycle load strobe to the downstream result register.
REQ-013 Port busy, output, 1: high in ACCUM and DONE.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-015 IDLE: in_ready=0; start=1 SHALL clear acc and beat count to 0 and move to ACCUM on the next edge.
REQ-016 ACCUM: in_ready=1; a beat is accepted only on in_valid=1 AND in_ready=1.
REQ-017 Each accepted beat SHALL form the full 2*WIDTH signed product, sign-extend it to ACC_WIDTH and add it to acc.
REQ-018 in_valid=0 in ACCUM SHALL hold acc and count unchanged, with no timeout.
REQ-019 When the beat that makes count equal LEN is accepted, the FSM SHALL move to DONE on the same edge; LEN=1 SHALL go to DONE after one beat.
REQ-020 DONE SHALL last exactly one cycle with ld=1 and in_ready=0, then return to IDLE.
REQ-021 result SHALL be registered on entry to DONE and is valid while ld=1; latency is the last accepted beat edge to ld high, one cycle.
REQ-022 start asserted in ACCUM or DONE SHALL be ignored and SHALL NOT restart the operation.
REQ-023 start asserted in the IDLE cycle right after DONE SHALL be honoured, allowing back-to-back operations with one idle cycle.
REQ-024 result SHALL keep its last value until the next DONE.
REQ-025 The count register SHALL be $clog2(LEN+1) bits wide and never wrap.

Reset
REQ-026 While rst_n=1, the block SHALL asynchronously force state=IDLE, acc=0, count=0, result=0, ld=0, in_ready=0 and busy=0.
REQ-027 Reset asserted mid-ACCUM or in DONE SHALL abort the operation with no ld pulse, and the partial sum SHALL be lost.
REQ-028 After rst_n deasserts, the first start SHALL be honoured on the first falling edge.

Configuration
REQ-029 Macro MAC_ACCUM_SATURATE_EN SHALL select the accumulator overflow behaviour.
REQ-030 With MAC_ACCUM_SATURATE_EN defined, each add that overflows SHALL clamp acc to 2^(ACC_WIDTH-1)-1, and each add that underflows SHALL clamp it to -2^(ACC_WIDTH-1).
REQ-031 Without MAC_ACCUM_SATURATE_EN, adds SHALL wrap modulo 2^ACC_WIDTH, and no saturation logic shall be present.

Verification
REQ-032 Reset check: hold rst_n=1 with random inputs -> result=0, ld=0, in_ready=0, busy=0; rst_n=0 then start -> busy=1 one edge later.
REQ-033 Basic sum (WIDTH=8, LEN=4): start, then pairs (3,4), (-2,5), (7,7), (0,9) on consecutive cycles -> ld=1 for exactly one cycle, the cycle after the 4th beat, with result=51.
REQ-034 Stalls: same pairs with in_valid low for 3 cycles between each beat -> result=51, busy=1 throughout, exactly one ld pulse.
REQ-035 Overflow (ACC_WIDTH=16): four beats of (-128,-128) -> result=0 without the macro; result=32767 with MAC_ACCUM_SATURATE_EN.
REQ-036 Abort: pulse rst_n after 2 of 4 beats -> no ld, result=0; a following full run of (1,1)x4 -> result=4.
REQ-037 Start while busy: pulse start during beats 2 and 3 of the run in REQ-033 -> a single ld with result=51, no restart; start in the cycle after DONE -> a new run begins.

Source files
------------

// File: rtl/mac_accum_ctrl_if.sv
// ============================================================================
// Module : mac_accum_ctrl_if
// Brief  : Operand/result bundle between a MAC accumulator and its user.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mac_accum_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
);
  logic                    start;
  logic signed [WIDTH-1:0] a_in;
  logic signed [WIDTH-1:0] b_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [ACC_WIDTH-1:0]    result;
  logic                    ld;
  logic                    busy;

  modport master (
    output start, a_in, b_in, in_valid,
    input  in_ready, result, ld, busy
  );

  modport slave (
    input  start, a_in, b_in, in_valid,
    output in_ready, result, ld, busy
  );
endinterface

`default_nettype wire

// File: rtl/mac_accum_ctrl.sv
// ============================================================================
// Module : mac_accum_ctrl
// Brief  : Signed dot-product accumulator over LEN operand pairs, falling-edge
//          clocked. Define MAC_ACCUM_SATURATE_EN for clamping adds (else wrap).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_accum_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20,
  parameter int LEN       = 4
) (
  input  wire logic          clk_n,
  input  wire logic          rst_n,
  mac_accum_ctrl_if.slave    bus
);

  localparam int c_cnt_w = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]          r_result;
  logic [c_cnt_w-1:0]            r_count;

  logic                          w_fire;
  logic                          w_last;
  logic signed [2*WIDTH-1:0]     w_a_ext;
  logic signed [2*WIDTH-1:0]     w_b_ext;
  logic signed [2*WIDTH-1:0]     w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prod_ext;
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic signed [ACC_WIDTH-1:0]   w_acc_next;

  assign w_fire = (r_state == S_ACCUM) && bus.in_valid;
  assign w_last = w_fire && (r_count == c_cnt_w'(LEN - 1));

  // Operands widened first so the multiply yields the exact signed product.
  assign w_a_ext    = (2*WIDTH)'(bus.a_in);
  assign w_b_ext    = (2*WIDTH)'(bus.b_in);
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;

`ifdef MAC_ACCUM_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic w_ovf;

  // Overflow only when both addends share a sign the sum does not.
  assign w_ovf      = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
  assign w_acc_next = w_ovf ? (r_acc[ACC_WIDTH-1] ? c_acc_min : c_acc_max) : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_ACCUM;
      S_ACCUM: if (w_last)    w_state_next = S_DONE;
      S_DONE:                 w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(negedge clk_n or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(negedge clk_n or posedge rst_n) begin
    if (rst_n) begin
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_fire) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_result <= w_acc_next;
      end
    end
  end

  assign bus.in_ready = (r_state == S_ACCUM);
  assign bus.ld       = (r_state == S_DONE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.result   = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mac_accum_ctrl.sv
// ============================================================================
// Module : tb_mac_accum_ctrl
// Brief  : Scoreboard bench for mac_accum_ctrl (WIDTH=8, ACC_WIDTH=16, LEN=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_accum_ctrl;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp_t;

  logic clk_n;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  mac_accum_ctrl_if #(.WIDTH(8), .ACC_WIDTH(16)) bus ();

  mac_accum_ctrl #(.WIDTH(8), .ACC_WIDTH(16), .LEN(4)) u_dut (
    .clk_n (clk_n),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk_n = 1'b1;
  always #5 clk_n = ~clk_n;

  initial cyc = 0;
  always @(negedge clk_n) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_n);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int a[4], input int b[4], input int gap,
                      input bit start_mid, input logic [15:0] exp);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      bus.a_in     = 8'(a[i]);
      bus.b_in     = 8'(b[i]);
      bus.in_valid = 1'b1;
      bus.start    = start_mid && (i == 1 || i == 2);
      tick();
      if (i == 3) begin
        e.res = exp;
        e.cyc = cyc;
        sb_q.push_back(e);
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check("busy_in_stall", 32'(bus.busy), 32'd1);
        end
      end
    end
    tick();
  endtask

  // Monitor: every ld pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_n);
      if (!rst_n && bus.ld) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ld", 32'(bus.result), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("result", 32'(bus.result), 32'(e.res));
          check("ld_cycle", 32'(cyc), 32'(e.cyc));
          check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_ovf;
    logic [15:0] exp_udf;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.in_valid = 1'b0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      bus.start    = 1'($urandom);
      bus.in_valid = 1'($urandom);
      bus.a_in     = 8'($urandom);
      bus.b_in     = 8'($urandom);
      tick();
    end
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ld", 32'(bus.ld), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    do_start();
    check("busy_after_start", 32'(bus.busy), 32'd1);

    // Basic run straight out of reset: 12 - 10 + 49 + 0 = 51.
    feed('{3, -2, 7, 0}, '{4, 5, 7, 9}, 0, 1'b0, 16'd51);

    do_start();
    feed('{3, -2, 7, 0}, '{4, 5, 7, 9}, 3, 1'b0, 16'd51);

    // start during beats 2 and 3 must be ignored; then a back-to-back run.
    do_start();
    feed('{3, -2, 7, 0}, '{4, 5, 7, 9}, 0, 1'b1, 16'd51);
    do_start();
    // -1 - 6 - 16256 + 25 = -16238
    feed('{-1, 2, -128, 5}, '{1, -3, 127, 5}, 0, 1'b0, 16'hC092);

`ifdef MAC_ACCUM_SATURATE_EN
    exp_ovf = 16'h7FFF;
    exp_udf = 16'h8000;
`else
    exp_ovf = 16'h0000;
    exp_udf = 16'h0200;
`endif
    do_start();
    feed('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 0, 1'b0, exp_ovf);
    do_start();
    feed('{-128, -128, -128, -128}, '{127, 127, 127, 127}, 1, 1'b0, exp_udf);

    // Abort after two beats: no ld, everything cleared.
    do_start();
    bus.a_in = 8'sd5; bus.b_in = 8'sd5; bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("abort_ld", 32'(bus.ld), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst_n = 1'b0;
    do_start();
    feed('{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 1'b0, 16'd4);

    repeat (5) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
